// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types and packing helper for the ADC sweep packer
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    localparam int OUT_CH_LSB   = 16;
    localparam int SAMPLE_MAX_W = 16;

    function automatic logic [31:0] pack_word(input logic [SAMPLE_MAX_W-1:0] ch,
                                              input logic [SAMPLE_MAX_W-1:0] smp);
        logic [31:0] w;
        w = '0;
        w[OUT_CH_LSB +: SAMPLE_MAX_W] = ch;
        w[SAMPLE_MAX_W-1:0]           = smp;
        return w;
    endfunction

endpackage

// File: rtl/adc_seq_packer_frame.sv
// rtl/adc_seq_packer_frame.sv - one serial ADC frame: CS/SCLK timing and SDI/SDO shifting
module adc_spi_frame
    import adc_seq_pkg::*;
#(
    parameter int CH_W     = 3,
    parameter int SAMPLE_W = 16,
    parameter int CLK_DIV  = 4,
    parameter int CS_GAP   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_go,
    input  logic [CH_W-1:0]     ch_addr,
    input  logic                adc_sdo,
    output logic                adc_sclk,
    output logic                adc_cs_n,
    output logic                adc_sdi,
    output logic                frame_cap,
    output logic                gap_last,
    output logic [SAMPLE_W-1:0] rx_data
);
    localparam int CNT_W = $clog2(CLK_DIV + CS_GAP + 1);
    localparam int BIT_W = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [SAMPLE_W-1:0] tx_q, tx_d, rx_q, rx_d, tx_load;
    logic                sclk_q, sclk_d, cs_n_q, cs_n_d, sdi_q, sdi_d;
    logic                cnt_done, start_frame;

    assign cnt_done    = (cnt_q == '0);
    assign frame_cap   = (state_q == ST_HOLD) && cnt_done;
    assign gap_last    = (state_q == ST_GAP) && cnt_done;
    assign start_frame = frame_go && ((state_q == ST_IDLE) || gap_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_done ? cnt_q : cnt_q - 1'b1;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        sdi_d   = sdi_q;
        tx_load = '0;
        tx_load[SAMPLE_W-1 -: CH_W] = ch_addr;
        case (state_q)
            ST_SETUP: if (cnt_done) begin
                state_d = ST_SHIFT;
                cnt_d   = DIV_LAST;
                bit_d   = BIT_W'(SAMPLE_W - 1);
            end
            ST_SHIFT: if (cnt_done) begin
                cnt_d = DIV_LAST;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    // falling edge: capture SDO, advance the address bit
                    sclk_d = 1'b0;
                    rx_d   = {rx_q[SAMPLE_W-2:0], adc_sdo};
                    sdi_d  = tx_q[SAMPLE_W-2];
                    tx_d   = tx_q << 1;
                    if (bit_q == '0) state_d = ST_HOLD;
                    else             bit_d   = bit_q - 1'b1;
                end
            end
            ST_HOLD: if (cnt_done) begin
                state_d = ST_GAP;
                cs_n_d  = 1'b1;
                cnt_d   = GAP_LAST;
            end
            ST_GAP: if (cnt_done) state_d = ST_IDLE;
            default: ;
        endcase
        if (start_frame) begin
            state_d = ST_SETUP;
            cs_n_d  = 1'b0;
            cnt_d   = DIV_LAST;
            tx_d    = tx_load;
            sdi_d   = ch_addr[CH_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            sdi_q   <= sdi_d;
        end
    end

    assign adc_sclk = sclk_q;
    assign adc_cs_n = cs_n_q;
    assign adc_sdi  = sdi_q;
    assign rx_data  = rx_q;

endmodule

// File: rtl/adc_seq_packer.sv
// rtl/adc_seq_packer.sv - channel sweep control, result tagging, output register and drop counter
module adc_seq_packer
    import adc_seq_pkg::*;
#(
    parameter int  NUM_CH     = 8,
    parameter int  SAMPLE_W   = 16,
    parameter int  CLK_DIV    = 4,
    parameter int  CS_GAP     = 2,
    parameter int  RESULT_LAT = 0,
    localparam int CH_W       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            single,
    input  logic [CH_W-1:0] ch_count,
    input  logic            clr_drop,
    output logic            adc_sclk,
    output logic            adc_cs_n,
    output logic            adc_sdi,
    input  logic            adc_sdo,
    output logic [31:0]     out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            sweep_done,
    output logic [15:0]     drop_cnt
);
    logic                    busy_q, busy_d, single_q, single_d, start_prev_q;
    logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d, ch_addr;
    logic [CH_W:0]           fidx_q, fidx_d, last_idx, tag_idx;
    logic                    out_valid_q, out_valid_d;
    logic [31:0]             out_data_q, out_data_d;
    logic [15:0]             drop_cnt_q, drop_cnt_d;
    logic                    frame_go, frame_cap, gap_last, is_last;
    logic                    launch, idle_go, cont, gap_go, relatch, accept, emit, drop_inc;
    logic [SAMPLE_W-1:0]     rx_data;
    logic [SAMPLE_MAX_W-1:0] ch_ext, smp_ext;

    // with one frame of latency the sweep runs one extra frame to flush the last result
    assign last_idx = {1'b0, ch_cnt_q} + (CH_W+1)'(RESULT_LAT);
    assign is_last  = (fidx_q == last_idx);
    assign tag_idx  = (RESULT_LAT != 0) ? fidx_q - 1'b1 : fidx_q;

    always_comb begin
        launch   = single ? (start && !start_prev_q) : start;
        idle_go  = !busy_q && launch;
        cont     = is_last ? (!single_q && start) : (single_q || start);
        gap_go   = busy_q && gap_last && cont;
        relatch  = idle_go || (gap_go && is_last);
        busy_d   = busy_q;
        single_d = single_q;
        ch_cnt_d = ch_cnt_q;
        fidx_d   = fidx_q;
        if (relatch) begin
            single_d = single;
            ch_cnt_d = ch_count;
            fidx_d   = '0;
        end else if (gap_go) begin
            fidx_d = fidx_q + 1'b1;
        end
        if (idle_go)                busy_d = 1'b1;
        else if (gap_last && !cont) busy_d = 1'b0;
        frame_go = idle_go || gap_go;
        ch_addr  = (fidx_d > {1'b0, ch_cnt_d}) ? '0 : fidx_d[CH_W-1:0];

        ch_ext  = '0;
        ch_ext[CH_W-1:0] = tag_idx[CH_W-1:0];
        smp_ext = '0;
        smp_ext[SAMPLE_W-1:0] = rx_data;

        accept      = out_valid_q && out_ready;
        emit        = frame_cap && ((RESULT_LAT == 0) || (fidx_q != '0));
        out_valid_d = out_valid_q && !accept;
        out_data_d  = out_data_q;
        drop_inc    = 1'b0;
        if (emit) begin
            if (out_valid_q && !accept) begin
                drop_inc = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = pack_word(ch_ext, smp_ext);
            end
        end
        drop_cnt_d = drop_cnt_q;
        if (clr_drop)                                drop_cnt_d = '0;
        else if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            single_q     <= 1'b0;
            start_prev_q <= 1'b0;
            ch_cnt_q     <= '0;
            fidx_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            busy_q       <= busy_d;
            single_q     <= single_d;
            start_prev_q <= start;
            ch_cnt_q     <= ch_cnt_d;
            fidx_q       <= fidx_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    adc_spi_frame #(
        .CH_W     (CH_W),
        .SAMPLE_W (SAMPLE_W),
        .CLK_DIV  (CLK_DIV),
        .CS_GAP   (CS_GAP)
    ) u_frame (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_go  (frame_go),
        .ch_addr   (ch_addr),
        .adc_sdo   (adc_sdo),
        .adc_sclk  (adc_sclk),
        .adc_cs_n  (adc_cs_n),
        .adc_sdi   (adc_sdi),
        .frame_cap (frame_cap),
        .gap_last  (gap_last),
        .rx_data   (rx_data)
    );

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign sweep_done = busy_q && gap_last && is_last;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_adc_seq_packer.sv
// tb/tb_adc_seq_packer.sv - directed bench for adc_seq_packer with a behavioural serial ADC
module tb_adc_seq_packer;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0, single = 1'b0, clr_drop = 1'b0, out_ready = 1'b0;
    logic [2:0]  ch_count = 3'd0;
    logic        sclk[2], cs_n[2], sdi[2];
    logic        sdo[2] = '{1'b0, 1'b0};
    logic [31:0] out_data[2];
    logic        out_valid[2], busy[2], sweep_done[2];
    logic [15:0] drop_cnt[2];

    int checks = 0, failures = 0;

    // ADC model and output monitor state, one slot per instance
    logic        p_sclk[2] = '{1'b0, 1'b0}, p_cs[2] = '{1'b1, 1'b1}, p_sdi[2] = '{1'b0, 1'b0};
    int          bitn[2] = '{0, 0}, lowc[2] = '{0, 0}, highc[2] = '{0, 0};
    int          lo_len[2] = '{0, 0}, hi_len[2] = '{0, 0}, nfr[2] = '{0, 0};
    int          nwords[2] = '{0, 0}, nsd[2] = '{0, 0}, sdi_bad[2] = '{0, 0};
    int          mbase[2] = '{0, 0}, adc_mode[2] = '{0, 2};
    logic [15:0] adc_const = 16'h1234;
    logic [15:0] word[2], sh[2];
    logic [2:0]  prev_addr[2] = '{3'd0, 3'd0};
    logic [31:0] wlog[2][64];
    logic [15:0] slog[2][64];

    always #5 clk = ~clk;

    adc_seq_packer #(.RESULT_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .single(single), .ch_count(ch_count),
        .clr_drop(clr_drop), .adc_sclk(sclk[0]), .adc_cs_n(cs_n[0]), .adc_sdi(sdi[0]),
        .adc_sdo(sdo[0]), .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .busy(busy[0]), .sweep_done(sweep_done[0]), .drop_cnt(drop_cnt[0])
    );

    adc_seq_packer #(.RESULT_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .single(single), .ch_count(ch_count),
        .clr_drop(clr_drop), .adc_sclk(sclk[1]), .adc_cs_n(cs_n[1]), .adc_sdi(sdi[1]),
        .adc_sdo(sdo[1]), .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .busy(busy[1]), .sweep_done(sweep_done[1]), .drop_cnt(drop_cnt[1])
    );

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!cs_n[g] && p_cs[g]) begin
                hi_len[g] = highc[g];
                lowc[g]   = 0;
                bitn[g]   = 0;
                sh[g]     = '0;
                case (adc_mode[g])
                    0:       word[g] = adc_const;
                    1:       word[g] = 16'hA000 | 16'(nfr[g] - mbase[g]);
                    default: word[g] = 16'hA000 | {13'd0, prev_addr[g]};
                endcase
            end
            if (cs_n[g] && !p_cs[g]) begin
                lo_len[g] = lowc[g];
                highc[g]  = 0;
                if (bitn[g] == 16) begin
                    slog[g][nfr[g] % 64] = sh[g];
                    prev_addr[g] = sh[g][15:13];
                    nfr[g]++;
                end
            end
            if (!cs_n[g]) begin
                lowc[g]++;
                if (sclk[g] && !p_sclk[g] && bitn[g] < 16) begin
                    sdo[g] = word[g][15 - bitn[g]];
                    sh[g]  = {sh[g][14:0], sdi[g]};
                    bitn[g]++;
                end
                if (!p_cs[g] && sdi[g] != p_sdi[g] && !(p_sclk[g] && !sclk[g])) sdi_bad[g]++;
            end else begin
                highc[g]++;
            end
            if (out_valid[g] && out_ready) begin
                wlog[g][nwords[g] % 64] = out_data[g];
                nwords[g]++;
            end
            if (sweep_done[g]) nsd[g]++;
            p_cs[g]   = cs_n[g];
            p_sclk[g] = sclk[g];
            p_sdi[g]  = sdi[g];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic kick(input int g);
        if (g == 0) start0 = 1'b1;
        else        start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int g, input int budget);
        int n = 0;
        while (busy[g] && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("busy_falls_dut%0d", g), 32'(busy[g]), 32'd0);
        repeat (3) tick();
    endtask

    typedef struct {
        int          g;
        int          chc;
        int          nfr;
        int          nw;
        logic [31:0] last;
    } vec_t;

    vec_t vt[6];

    initial begin
        int w0, f0, s0, b0, n;
        int expa;

        vt[0] = '{0, 3, 4, 4, 32'h0003A003};
        vt[1] = '{1, 3, 5, 4, 32'h0003A003};
        vt[2] = '{0, 0, 1, 1, 32'h0000A000};
        vt[3] = '{1, 0, 2, 1, 32'h0000A000};
        vt[4] = '{0, 7, 8, 8, 32'h0007A007};
        vt[5] = '{1, 2, 4, 3, 32'h0002A002};

        repeat (3) tick();
        chk("rst_cs_n", 32'(cs_n[0]), 32'd1);
        chk("rst_sclk", 32'(sclk[0]), 32'd0);
        chk("rst_sdi", 32'(sdi[0]), 32'd0);
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_out_data", out_data[0], 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_sweep_done", 32'(sweep_done[0]), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        // continuous sweep of channel 0 with a constant sample
        adc_mode[0] = 0;
        single = 1'b0;
        ch_count = 3'd0;
        out_ready = 1'b1;
        w0 = nwords[0];
        start0 = 1'b1;
        n = 0;
        while (nwords[0] - w0 < 3 && n < 1000) begin
            tick();
            n++;
        end
        start0 = 1'b0;
        chk("cont_three_words", 32'(nwords[0] - w0 >= 3), 32'd1);
        for (int k = 0; k < 3; k++)
            chk($sformatf("cont_word%0d", k), wlog[0][(w0 + k) % 64], 32'h00001234);
        chk("cs_low_cycles", 32'(lo_len[0]), 32'd136);
        chk("cs_high_cycles", 32'(hi_len[0]), 32'd2);
        wait_idle(0, 400);

        // single sweeps from the vector table
        adc_mode[0] = 1;
        adc_mode[1] = 2;
        single = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int g;
            g = vt[i].g;
            ch_count = 3'(vt[i].chc);
            w0 = nwords[g];
            f0 = nfr[g];
            s0 = nsd[g];
            b0 = sdi_bad[g];
            mbase[g] = nfr[g];
            kick(g);
            wait_idle(g, 200 * (vt[i].nfr + 1));
            chk($sformatf("v%0d_frames", i), 32'(nfr[g] - f0), 32'(vt[i].nfr));
            chk($sformatf("v%0d_words", i), 32'(nwords[g] - w0), 32'(vt[i].nw));
            chk($sformatf("v%0d_sweep_done", i), 32'(nsd[g] - s0), 32'd1);
            chk($sformatf("v%0d_sdi_edges", i), 32'(sdi_bad[g] - b0), 32'd0);
            chk($sformatf("v%0d_cs_idle", i), 32'(cs_n[g]), 32'd1);
            for (int k = 0; k < vt[i].nw; k++)
                chk($sformatf("v%0d_word%0d", i, k), wlog[g][(w0 + k) % 64],
                    {16'(k), 16'hA000 | 16'(k)});
            chk($sformatf("v%0d_last_word", i), wlog[g][(w0 + vt[i].nw - 1) % 64], vt[i].last);
            for (int k = 0; k < vt[i].nfr; k++) begin
                expa = (k <= vt[i].chc) ? k : 0;
                chk($sformatf("v%0d_sdi_frame%0d", i, k), 32'(slog[g][(f0 + k) % 64]),
                    32'(expa) << 13);
            end
            if (vt[i].chc == 7)
                chk("sdi_ch5_pattern", 32'(slog[g][(f0 + 5) % 64]), 32'h0000A000);
        end

        // backpressure: first word held, later ones dropped
        ch_count = 3'd2;
        out_ready = 1'b0;
        mbase[0] = nfr[0];
        kick(0);
        wait_idle(0, 800);
        chk("drop_hold_data", out_data[0], 32'h0000A000);
        chk("drop_hold_valid", 32'(out_valid[0]), 32'd1);
        chk("drop_cnt_two", 32'(drop_cnt[0]), 32'd2);
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        chk("drop_cleared", 32'(drop_cnt[0]), 32'd0);
        force dut0.drop_cnt_q = 16'hFFFF;
        tick();
        release dut0.drop_cnt_q;
        tick();
        ch_count = 3'd0;
        kick(0);
        wait_idle(0, 400);
        chk("drop_saturated", 32'(drop_cnt[0]), 32'h0000FFFF);
        chk("drop_data_kept", out_data[0], 32'h0000A000);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("drain_valid_low", 32'(out_valid[0]), 32'd0);
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;

        // start dropped mid-shift in continuous mode
        single = 1'b0;
        ch_count = 3'd3;
        mbase[0] = nfr[0];
        w0 = nwords[0];
        f0 = nfr[0];
        s0 = nsd[0];
        start0 = 1'b1;
        n = 0;
        while (cs_n[0] && n < 50) begin
            tick();
            n++;
        end
        repeat (40) tick();
        start0 = 1'b0;
        wait_idle(0, 400);
        chk("stop_words", 32'(nwords[0] - w0), 32'd1);
        chk("stop_word", wlog[0][w0 % 64], 32'h0000A000);
        chk("stop_no_sweep_done", 32'(nsd[0] - s0), 32'd0);
        repeat (300) tick();
        chk("stop_frames", 32'(nfr[0] - f0), 32'd1);
        chk("stop_cs_idle", 32'(cs_n[0]), 32'd1);

        // reset asserted mid-shift
        out_ready = 1'b0;
        mbase[0] = nfr[0];
        w0 = nwords[0];
        f0 = nfr[0];
        start0 = 1'b1;
        n = 0;
        while (nfr[0] == f0 && n < 300) begin
            tick();
            n++;
        end
        n = 0;
        while (cs_n[0] && n < 50) begin
            tick();
            n++;
        end
        repeat (40) tick();
        chk("pre_reset_valid", 32'(out_valid[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_cs_n", 32'(cs_n[0]), 32'd1);
        chk("mid_reset_sclk", 32'(sclk[0]), 32'd0);
        chk("mid_reset_valid", 32'(out_valid[0]), 32'd0);
        chk("mid_reset_data", out_data[0], 32'd0);
        start0 = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (300) tick();
        chk("post_reset_words", 32'(nwords[0] - w0), 32'd0);
        chk("post_reset_frames", 32'(nfr[0] - f0), 32'd1);
        chk("post_reset_valid", 32'(out_valid[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
